cnn_sdiv_seq_25s_14s: RTL

//  Sequential signed fixed-point divider; the inverse of the layer multiplier datapath.

---
 rtl/cnn_arith_pkg.sv | 40 ++++
 rtl/cnn_udiv_step.sv | 24 ++
 rtl/cnn_sdiv_seq_25s_14s.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cnn_arith_pkg.sv
// Shared arithmetic definitions for the CNN divider datapath.
// Widths, FSM encoding, saturation limits and sign helpers.
package cnn_arith_pkg;

  localparam int unsigned DIVIDEND_W = 25;
  localparam int unsigned DIVISOR_W  = 14;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned REM_W      = DIVISOR_W + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [DIVIDEND_W-1:0] Q_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
  localparam logic [DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  // Magnitude as unsigned; the most negative value maps to 2^(W-1) without loss.
  function automatic logic [DIVIDEND_W-1:0] abs_dvd(input logic [DIVIDEND_W-1:0] x);
    return x[DIVIDEND_W-1] ? (~x + DIVIDEND_W'(1)) : x;
  endfunction

  function automatic logic [DIVISOR_W-1:0] abs_dvs(input logic [DIVISOR_W-1:0] x);
    return x[DIVISOR_W-1] ? (~x + DIVISOR_W'(1)) : x;
  endfunction

  function automatic logic [DIVIDEND_W-1:0] neg_dvd(input logic [DIVIDEND_W-1:0] x,
                                                    input logic n);
    return n ? (~x + DIVIDEND_W'(1)) : x;
  endfunction

  function automatic logic [DIVISOR_W-1:0] neg_dvs(input logic [DIVISOR_W-1:0] x,
                                                   input logic n);
    return n ? (~x + DIVISOR_W'(1)) : x;
  endfunction

endpackage

// File: rtl/cnn_udiv_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract,
// keep the difference when it does not go negative.
module cnn_udiv_step
  import cnn_arith_pkg::*;
(
  input  logic [REM_W-1:0] rem_in,
  input  logic [REM_W-1:0] dvs,
  input  logic             bit_in,
  output logic [REM_W-1:0] rem_out_c,
  output logic             q_bit_c
);

  logic [REM_W:0] shifted;
  logic [REM_W:0] diff;

  // rem_in < dvs <= 2^(DIVISOR_W-1) keeps shifted below 2^REM_W, so the top bit of diff is its sign
  always_comb begin
    shifted   = {rem_in, bit_in};
    diff      = shifted - {1'b0, dvs};
    q_bit_c   = ~diff[REM_W];
    rem_out_c = q_bit_c ? diff[REM_W-1:0] : shifted[REM_W-1:0];
  end

endmodule

// File: rtl/cnn_sdiv_seq_25s_14s.sv
// Sequential signed divider, 25-bit dividend by 14-bit divisor, truncating toward zero.
// One quotient bit per cycle; valid/ready handshake on operands and result.
module cnn_sdiv_seq_25s_14s
  import cnn_arith_pkg::*;
(
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  state_t state_q, state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVIDEND_W-1:0] mag_q;
  logic [REM_W-1:0]      dvs_mag_q;
  logic [REM_W-1:0]      rem_q;
  logic                  neg_d_q;
  logic                  neg_s_q;

  logic                  accept_c, prep_c, step_c, fix_c;
  logic [REM_W-1:0]      rem_nxt_c;
  logic                  q_bit_c;

  // State register; handshake outputs registered from the next state
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = PREP;
      PREP: state_d = (dvs_q == '0) ? FIX : CALC;
      CALC: if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes
  always_comb begin
    accept_c = 1'b0;
    prep_c   = 1'b0;
    step_c   = 1'b0;
    fix_c    = 1'b0;
    case (state_q)
      IDLE: accept_c = in_valid;
      PREP: prep_c   = 1'b1;
      CALC: step_c   = 1'b1;
      FIX:  fix_c    = 1'b1;
      default: ;
    endcase
  end

  cnn_udiv_step u_step (
    .rem_in    (rem_q),
    .dvs       (dvs_mag_q),
    .bit_in    (mag_q[DIVIDEND_W-1]),
    .rem_out_c (rem_nxt_c),
    .q_bit_c   (q_bit_c)
  );

  // Operand capture, magnitude iteration and sign-corrected result registers
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      mag_q       <= '0;
      dvs_mag_q   <= '0;
      rem_q       <= '0;
      neg_d_q     <= 1'b0;
      neg_s_q     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (accept_c) begin
        dvd_q       <= dividend;
        dvs_q       <= divisor;
        div_by_zero <= 1'b0;
        overflow    <= 1'b0;
      end
      if (prep_c) begin
        neg_d_q   <= dvd_q[DIVIDEND_W-1];
        neg_s_q   <= dvs_q[DIVISOR_W-1];
        mag_q     <= abs_dvd(dvd_q);
        dvs_mag_q <= {1'b0, abs_dvs(dvs_q)};
        rem_q     <= '0;
        cnt_q     <= CNT_W'(DIVIDEND_W);
      end
      // Quotient bits fill mag_q from the bottom as dividend bits leave the top
      if (step_c) begin
        mag_q <= {mag_q[DIVIDEND_W-2:0], q_bit_c};
        rem_q <= rem_nxt_c;
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (fix_c) begin
        if (dvs_q == '0) begin
          quotient    <= neg_d_q ? Q_MIN : Q_MAX;
          remainder   <= '0;
          div_by_zero <= 1'b1;
        end else if (dvd_q == Q_MIN && dvs_q == '1) begin
          quotient  <= Q_MAX;
          remainder <= '0;
          overflow  <= 1'b1;
        end else begin
          quotient  <= neg_dvd(mag_q, neg_d_q ^ neg_s_q);
          remainder <= neg_dvs(rem_q[DIVISOR_W-1:0], neg_d_q);
        end
      end
    end
  end

endmodule
